// File: rtl/avl_mm_st_stream_reader.sv
// Command-driven Avalon-MM pipelined burst reader. Each (address, length) command
// becomes one Avalon-ST packet, with read data buffered in a credit-protected FIFO.
`timescale 1ns/1ps
module avl_mm_st_stream_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_PENDING = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic                  mm_read,
  output logic [ADDR_WIDTH-1:0] mm_address,
  input  logic                  mm_waitrequest,
  input  logic [DATA_WIDTH-1:0] mm_readdata,
  input  logic                  mm_readdatavalid,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic                  st_sop,
  output logic                  st_eop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]        DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]      MAXP_C  = CNT_W'(MAX_PENDING);
  localparam logic [ADDR_WIDTH-1:0] STRIDE  = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_ready_en, r_done, r_sop;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_issue_left, r_beats_left;
  logic [CNT_W-1:0]      r_pending, r_count;
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic           w_cmd_fire, w_credit, w_accept, w_last_req;
  logic           w_push, w_pop, w_eop_fire;
  logic [CNT_W:0] w_occupancy;

  assign w_cmd_fire  = cmd_valid & cmd_ready;
  // Reserve a FIFO slot for every outstanding read so returning data can never overflow.
  assign w_occupancy = {1'b0, r_pending} + {1'b0, r_count};
  assign w_credit    = (r_pending < MAXP_C) && (w_occupancy < DEPTH_C);
  assign mm_read     = (r_state == S_ISSUE) && (r_issue_left != '0) && w_credit;
  assign w_accept    = mm_read & ~mm_waitrequest;
  assign w_last_req  = w_accept && (r_issue_left == LEN_WIDTH'(1));
  assign w_push      = mm_readdatavalid && (r_pending != '0);

  assign st_valid    = (r_count != '0);
  assign w_pop       = st_valid & st_ready;
  assign st_data     = r_mem[r_rd_ptr];
  assign st_sop      = st_valid & r_sop;
  assign st_eop      = st_valid & (r_beats_left == LEN_WIDTH'(1));
  assign w_eop_fire  = w_pop & st_eop;

  assign cmd_ready   = r_ready_en & (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign mm_address  = r_addr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: the default assignment comes first so no path leaves w_state_nxt unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_cmd_fire && (cmd_len != '0)) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_last_req)                    w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_eop_fire)                    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready_en   <= 1'b0;
      r_done       <= 1'b0;
      r_sop        <= 1'b0;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_beats_left <= '0;
      r_pending    <= '0;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_done     <= w_eop_fire | (w_cmd_fire && (cmd_len == '0));

      if (w_cmd_fire) begin
        r_addr       <= cmd_addr;
        r_issue_left <= cmd_len;
      end else if (w_accept) begin
        r_addr       <= r_addr + STRIDE;
        r_issue_left <= r_issue_left - LEN_WIDTH'(1);
      end

      // The FIFO is always empty in IDLE, so a new command never races a pop.
      if (w_cmd_fire) begin
        r_beats_left <= cmd_len;
        r_sop        <= 1'b1;
      end else if (w_pop) begin
        r_beats_left <= r_beats_left - LEN_WIDTH'(1);
        r_sop        <= 1'b0;
      end

      unique case ({w_accept, w_push})
        2'b10:   r_pending <= r_pending + CNT_W'(1);
        2'b01:   r_pending <= r_pending - CNT_W'(1);
        default: r_pending <= r_pending;
      endcase

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: storage is not reset; the cleared pointers and count make stale contents unobservable.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= mm_readdata;
  end

endmodule
